// File: rtl/ram_mmio_pkg.sv
// Shared defaults for the data RAM with motor mailboxes, plus the status-word packer.
package ram_mmio_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 12;
    localparam int DEPTH         = 4096;
    localparam int MOTOR_BASE    = 10;
    localparam int STATUS_ADDR   = 4095;
    localparam int MAX_MOTORS    = 16;

    // Status layout: overrun flags sit directly above the n valid flags.
    function automatic logic [31:0] pack_status(input logic [15:0] valid,
                                                input logic [15:0] ovr,
                                                input int          n);
        logic [31:0] mask;
        mask = (32'h1 << n) - 32'h1;
        return (({16'h0, ovr} & mask) << n) | ({16'h0, valid} & mask);
    endfunction

endpackage

// File: rtl/ram_mmio_motor_mailbox.sv
// One motor mailbox channel: position mirror, valid/ready handshake and sticky overrun flag.
module motor_mailbox #(
    parameter int POS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hit,
    input  logic [POS_WIDTH-1:0] wdata,
    input  logic                 ready,
    input  logic                 clr_ovr,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 valid,
    output logic                 overrun
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // A new hit keeps valid high even if the old value is consumed on this edge.
            if (hit) begin
                pos   <= wdata;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (hit && valid && !ready) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram_mmio.sv
// Single-port data RAM with a window of addresses mirrored into motor mailboxes and a status word.
module ram_mmio #(
    parameter int DATA_WIDTH    = ram_mmio_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = ram_mmio_pkg::ADDRESS_WIDTH,
    parameter int DEPTH         = ram_mmio_pkg::DEPTH,
    parameter int NUM_MOTORS    = 2,
    parameter int POS_WIDTH     = 32,
    parameter int MOTOR_BASE    = ram_mmio_pkg::MOTOR_BASE,
    parameter int STATUS_ADDR   = ram_mmio_pkg::STATUS_ADDR
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             wEn,
    input  logic [ADDRESS_WIDTH-1:0]         addr,
    input  logic [DATA_WIDTH-1:0]            dataIn,
    output logic [DATA_WIDTH-1:0]            dataOut,
    output logic [NUM_MOTORS*POS_WIDTH-1:0]  motor_pos,
    output logic [NUM_MOTORS-1:0]            motor_valid,
    input  logic [NUM_MOTORS-1:0]            motor_ready
);
    import ram_mmio_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_L  = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] STATUS_L = ADDRESS_WIDTH'(STATUS_ADDR);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_in_range;
    logic                  w_is_status;
    logic                  w_clr_ovr;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_MOTORS-1:0] w_ovr;
    logic [DATA_WIDTH-1:0] w_status;

    assign w_in_range  = ({1'b0, addr} < DEPTH_L);
    assign w_is_status = (addr == STATUS_L);
    assign w_idx       = addr[IDX_W-1:0];
    assign w_clr_ovr   = !wEn && w_is_status;
    assign w_status    = DATA_WIDTH'(pack_status(16'(motor_valid), 16'(w_ovr), NUM_MOTORS));

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wEn && w_in_range && !w_is_status) begin
            r_mem[w_idx] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOut <= '0;
        end else if (!wEn) begin
            if (w_is_status) begin
                dataOut <= w_status;
            end else if (w_in_range) begin
                dataOut <= r_mem[w_idx];
            end else begin
                dataOut <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_mbx
        logic w_hit;
        assign w_hit = wEn && (addr == ADDRESS_WIDTH'(MOTOR_BASE + k));

        motor_mailbox #(
            .POS_WIDTH (POS_WIDTH)
        ) u_mbx (
            .clk     (clk),
            .reset_n (reset_n),
            .hit     (w_hit),
            .wdata   (dataIn[POS_WIDTH-1:0]),
            .ready   (motor_ready[k]),
            .clr_ovr (w_clr_ovr),
            .pos     (motor_pos[k*POS_WIDTH +: POS_WIDTH]),
            .valid   (motor_valid[k]),
            .overrun (w_ovr[k])
        );
    end

endmodule
